// File: rtl/fft_bitrev_reorder_if.sv
// Valid/ready bundle around the FFT output reorder stage: bit-reversed samples in, natural-order samples out.
interface fft_bitrev_reorder_if #(
   parameter int DATA = 9
);
   logic                   in_valid;
   logic                   in_ready;
   logic signed [DATA-1:0] in_re;
   logic signed [DATA-1:0] in_im;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [DATA-1:0] out_re;
   logic signed [DATA-1:0] out_im;
   logic                   out_last;

   // Master is the surrounding pipeline (producer plus consumer); slave is the reorder block.
   modport master (
      output in_valid, in_re, in_im, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_last
   );

   modport slave (
      input  in_valid, in_re, in_im, out_ready,
      output in_ready, out_valid, out_re, out_im, out_last
   );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong frame buffer that re-emits each FFT frame in natural order.
// Define FFT_REORDER_BITREV_EN for bit-reversed write addressing; otherwise frames pass in input order.
module fft_bitrev_reorder #(
   parameter  int DATA = 9,
   parameter  int N    = 16,
   localparam int LOGN = $clog2(N)
) (
   input logic                 clk,
   input logic                 rst,
   fft_bitrev_reorder_if.slave bus
);

   localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

   logic [2*DATA-1:0]      mem_q [2][N];
   logic [1:0]             full_q, full_d;
   logic                   wr_bank_q, wr_bank_d;
   logic                   rd_bank_q, rd_bank_d;
   logic [LOGN-1:0]        wcnt_q, wcnt_d;
   logic [LOGN-1:0]        rcnt_q, rcnt_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_last_q, out_last_d;
   logic signed [DATA-1:0] out_re_q, out_re_d;
   logic signed [DATA-1:0] out_im_q, out_im_d;
   logic [LOGN-1:0]        wr_addr;
   logic                   wr_fire;
   logic                   rd_load;

`ifdef FFT_REORDER_BITREV_EN
   function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
      logic [LOGN-1:0] r;
      for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
      return r;
   endfunction

   assign wr_addr = bitrev(wcnt_q);
`else
   assign wr_addr = wcnt_q;
`endif

   assign wr_fire = bus.in_valid && !full_q[wr_bank_q];
   assign rd_load = full_q[rd_bank_q] && (!out_valid_q || bus.out_ready);

   // NOTE: every next-state signal takes its current value first, so no path through this block can infer a latch.
   always_comb begin
      full_d      = full_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wcnt_d      = wcnt_q;
      rcnt_d      = rcnt_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;

      if (wr_fire) begin
         wcnt_d = wcnt_q + 1'b1;
         if (wcnt_q == LAST_IDX) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wcnt_d            = '0;
         end
      end

      // Set targets a non-full bank and clear a full one, so both may act in the same cycle.
      if (rd_load) begin
         {out_re_d, out_im_d} = mem_q[rd_bank_q][rcnt_q];
         out_valid_d          = 1'b1;
         out_last_d           = (rcnt_q == LAST_IDX);
         rcnt_d               = rcnt_q + 1'b1;
         if (rcnt_q == LAST_IDX) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
            rcnt_d            = '0;
         end
      end else if (bus.out_ready && out_valid_q) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
      end else begin
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
      end
   end

   // NOTE: sample memory has no reset; the full flags guarantee no entry is read before it is written.
   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_bank_q][wr_addr] <= {bus.in_re, bus.in_im};
   end

   assign bus.in_ready  = !full_q[wr_bank_q];
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_re    = out_re_q;
   assign bus.out_im    = out_im_q;

endmodule
